if_fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RV32I core.
- Owns the PC, issues requests to instruction memory (variable-latency, in-order responses), and buffers returned words in a small FIFO.
- Presents {pc, instr, valid} to decode.
- Directly consumes the hazard unit's PCWrite/IFIDWrite stall outputs and the EX-stage branch redirect.

---
 rtl/if_fetch_stage.sv | 178 +++++++++++++++++
 tb/tb_if_fetch_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage and IF/ID register, with a credit-limited fetch buffer.
// Define FETCH_PERF_CNT_EN to build the stall/flush performance counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        ifid_write,
    input  logic        flush,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);
    // Storage is sized for the largest legal depth (4); only FIFO_DEPTH entries are used.
    localparam int               PTR_W   = 2;
    localparam int               CNT_W   = 3;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);

    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] r_fifo_cnt;
    logic [31:0]      r_rq_pc [4];
    logic [PTR_W-1:0] r_rq_wr;
    logic [PTR_W-1:0] r_rq_rd;
    logic [31:0]      r_fb_pc [4];
    logic [31:0]      r_fb_instr [4];
    logic [PTR_W-1:0] r_fb_wr;
    logic [PTR_W-1:0] r_fb_rd;
    logic [31:0]      r_ifid_pc;
    logic [31:0]      r_ifid_instr;
    logic             r_ifid_valid;

    logic             w_grant;
    logic             w_resp_push;
    logic             w_fb_empty;
    logic             w_head_avail;
    logic             w_ifid_load;
    logic [CNT_W-1:0] w_inflight;
    logic [31:0]      w_req_pc;
    logic [31:0]      w_head_pc;
    logic [31:0]      w_head_instr;
    logic [1:0]       w_unused_tgt_lsb;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_C) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits cover both in-flight requests and buffered words, so the buffer never overflows.
    assign w_inflight   = r_outstanding + r_fifo_cnt;
    assign imem_req     = !rst && !flush && pc_write && (w_inflight < DEPTH_C);
    assign imem_addr    = r_pc;
    assign w_grant      = imem_req && imem_gnt;
    assign w_req_pc     = r_rq_pc[r_rq_rd];

    assign w_resp_push  = imem_rvalid && (r_drop_cnt == '0) && !flush;
    assign w_fb_empty   = (r_fifo_cnt == '0);
    assign w_head_pc    = w_fb_empty ? w_req_pc   : r_fb_pc[r_fb_rd];
    assign w_head_instr = w_fb_empty ? imem_rdata : r_fb_instr[r_fb_rd];
    assign w_head_avail = !w_fb_empty || w_resp_push;
    assign w_ifid_load  = ifid_write && w_head_avail && !flush;

    assign w_unused_tgt_lsb = branch_target[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_rq_wr       <= '0;
            r_rq_rd       <= '0;
        end else begin
            if (flush)
                r_pc <= {branch_target[31:2], 2'b00};
            else if (w_grant)
                r_pc <= r_pc + 32'd4;
            if (w_grant)
                r_rq_wr <= ptr_inc(r_rq_wr);
            if (imem_rvalid)
                r_rq_rd <= ptr_inc(r_rq_rd);
            r_outstanding <= r_outstanding + CNT_W'(w_grant) - CNT_W'(imem_rvalid);
            // Every response still in flight after a redirect belongs to the wrong path.
            if (flush)
                r_drop_cnt <= r_outstanding - CNT_W'(imem_rvalid);
            else if (imem_rvalid && (r_drop_cnt != '0))
                r_drop_cnt <= r_drop_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_fb_wr    <= '0;
            r_fb_rd    <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_resp_push)
                r_fb_wr <= ptr_inc(r_fb_wr);
            if (w_ifid_load)
                r_fb_rd <= ptr_inc(r_fb_rd);
            r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_resp_push) - CNT_W'(w_ifid_load);
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant)
            r_rq_pc[r_rq_wr] <= r_pc;
        if (w_resp_push) begin
            r_fb_pc[r_fb_wr]    <= w_req_pc;
            r_fb_instr[r_fb_wr] <= imem_rdata;
        end
    end

    // IF/ID register: an empty buffer lets a same-cycle response bypass straight in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc    <= '0;
        end else if (flush) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
        end else if (ifid_write) begin
            if (w_head_avail) begin
                r_ifid_valid <= 1'b1;
                r_ifid_instr <= w_head_instr;
                r_ifid_pc    <= w_head_pc;
            end else begin
                r_ifid_valid <= 1'b0;
                r_ifid_instr <= NOP_INSTR;
            end
        end
    end

    assign ifid_pc    = r_ifid_pc;
    assign ifid_instr = r_ifid_instr;
    assign ifid_valid = r_ifid_valid;

    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid && (r_outstanding == '0)));
    a_no_fb_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_resp_push && (r_fifo_cnt == DEPTH_C)));

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!ifid_write && r_ifid_valid)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (flush)
                r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with an in-order, fixed-latency instruction memory model.
module tb_if_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic        ifid_write;
    logic        flush;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    int n_cmp = 0;
    int n_bad = 0;
    int lat = 1;
    int g_count = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2),
        .NOP_INSTR (NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .flush        (flush),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .ifid_pc      (ifid_pc),
        .ifid_instr   (ifid_instr),
        .ifid_valid   (ifid_valid),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    // Memory model: samples the handshake just before each rising edge, answers in order
    // 'lat' cycles after the grant with rdata = addr | 0xA00.
    logic [31:0] q_addr[$];
    int          q_due[$];
    int          edge_n = 0;
    logic        smp_g;
    logic        smp_r;
    logic [31:0] smp_a;

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            #4;
            smp_g = imem_req && imem_gnt;
            smp_a = imem_addr;
            smp_r = rst;
            @(posedge clk);
            #1;
            edge_n++;
            if (smp_r === 1'b1) begin
                q_addr.delete();
                q_due.delete();
            end else if (smp_g === 1'b1) begin
                q_addr.push_back(smp_a);
                q_due.push_back(edge_n + lat);
                g_count++;
            end
            if (smp_r !== 1'b1 && q_addr.size() > 0 && q_due[0] <= edge_n + 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = q_addr[0] | 32'h0000_0A00;
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input int l);
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; pc_write = 1'b1; ifid_write = 1'b1;
        branch_target = '0; imem_gnt = 1'b1; lat = l;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; pc_write = 1'b1; ifid_write = 1'b1;
        branch_target = '0; imem_gnt = 1'b1; lat = 1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_cmp++; if (ifid_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", ifid_valid); end
        n_cmp++; if (ifid_instr !== NOP) begin n_bad++; $display("FAIL reset_instr: got %h want %h", ifid_instr, NOP); end
        n_cmp++; if (ifid_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", ifid_pc); end
        rst = 1'b0; #1;
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL first_req: got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL first_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_straight();
        bit ok = 1'b0;
        logic [31:0] exp_pc;
        do_reset(1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (ifid_valid === 1'b1) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL straight_timeout: got no valid want valid"); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            exp_pc = 32'(4 * i);
            n_cmp++; if (ifid_pc !== exp_pc) begin n_bad++; $display("FAIL straight_pc[%0d]: got %h want %h", i, ifid_pc, exp_pc); end
            n_cmp++; if (ifid_instr !== (exp_pc | 32'hA00)) begin n_bad++; $display("FAIL straight_instr[%0d]: got %h want %h", i, ifid_instr, exp_pc | 32'hA00); end
            n_cmp++; if (ifid_valid !== 1'b1) begin n_bad++; $display("FAIL straight_valid[%0d]: got %b want 1", i, ifid_valid); end
        end
    endtask

    task automatic test_stall();
        bit ok = 1'b0;
        int g0;
        logic [31:0] exp_pc;
        do_reset(1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (ifid_valid === 1'b1 && ifid_pc === 32'h8) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_timeout: got no pc 8 want pc 8"); end
        pc_write = 1'b0; ifid_write = 1'b0; g0 = g_count; #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL stall_req: got %b want 0", imem_req); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_cmp++; if (ifid_pc !== 32'h8) begin n_bad++; $display("FAIL stall_hold_pc[%0d]: got %h want 8", i, ifid_pc); end
            n_cmp++; if (ifid_instr !== 32'hA08) begin n_bad++; $display("FAIL stall_hold_instr[%0d]: got %h want a08", i, ifid_instr); end
            n_cmp++; if (ifid_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold_valid[%0d]: got %b want 1", i, ifid_valid); end
        end
        n_cmp++; if (g_count != g0) begin n_bad++; $display("FAIL stall_grants: got %0d want 0", g_count - g0); end
        // Fetch re-enabled while decode is still held: only one credit remains.
        pc_write = 1'b1; g0 = g_count;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (g_count - g0 != 1) begin n_bad++; $display("FAIL credit_grants: got %0d want 1", g_count - g0); end
        n_cmp++; if (ifid_pc !== 32'h8) begin n_bad++; $display("FAIL credit_hold_pc: got %h want 8", ifid_pc); end
        ifid_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            exp_pc = 32'hC + 32'(4 * i);
            n_cmp++; if (ifid_pc !== exp_pc) begin n_bad++; $display("FAIL resume_pc[%0d]: got %h want %h", i, ifid_pc, exp_pc); end
            n_cmp++; if (ifid_valid !== 1'b1) begin n_bad++; $display("FAIL resume_valid[%0d]: got %b want 1", i, ifid_valid); end
        end
    endtask

    task automatic test_flush();
        bit ok = 1'b0;
        do_reset(3);
        repeat (2) @(negedge clk);
        #1;
        flush = 1'b1; branch_target = 32'h100; #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL flush_req: got %b want 0", imem_req); end
        @(negedge clk); #1;
        flush = 1'b0;
        n_cmp++; if (ifid_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", ifid_valid); end
        n_cmp++; if (ifid_instr !== NOP) begin n_bad++; $display("FAIL flush_instr: got %h want %h", ifid_instr, NOP); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (ifid_valid === 1'b1) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL flush_timeout: got no valid want valid"); end
        n_cmp++; if (ifid_pc !== 32'h100) begin n_bad++; $display("FAIL flush_target_pc: got %h want 100", ifid_pc); end
        n_cmp++; if (ifid_instr !== 32'hB00) begin n_bad++; $display("FAIL flush_target_instr: got %h want b00", ifid_instr); end
        // Unaligned target while decode is held: flush still wins and the target is word-aligned.
        flush = 1'b1; branch_target = 32'h102; ifid_write = 1'b0;
        @(negedge clk); #1;
        flush = 1'b0; ifid_write = 1'b1; #1;
        n_cmp++; if (ifid_valid !== 1'b0) begin n_bad++; $display("FAIL flush2_valid: got %b want 0", ifid_valid); end
        n_cmp++; if (ifid_instr !== NOP) begin n_bad++; $display("FAIL flush2_instr: got %h want %h", ifid_instr, NOP); end
        n_cmp++; if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL flush2_align_addr: got %h want 100", imem_addr); end
        n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL flush2_req: got %b want 1", imem_req); end
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (ifid_valid === 1'b1) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL flush2_timeout: got no valid want valid"); end
        n_cmp++; if (ifid_pc !== 32'h100) begin n_bad++; $display("FAIL flush2_pc: got %h want 100", ifid_pc); end
    endtask

    task automatic test_flush_race();
        bit ok = 1'b0;
        do_reset(3);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (ifid_valid === 1'b1) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok || ifid_pc !== 32'h0) begin n_bad++; $display("FAIL race_first_pc: got %h want 0", ifid_pc); end
        @(negedge clk); #1;
        n_cmp++; if (ifid_pc !== 32'h4) begin n_bad++; $display("FAIL race_second_pc: got %h want 4", ifid_pc); end
        ifid_write = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4) begin n_bad++; $display("FAIL race_hold: got %b/%h want 1/4", ifid_valid, ifid_pc); end
        // Flush lands with a response arriving and one more still in flight.
        flush = 1'b1; branch_target = 32'h300;
        @(negedge clk); #1;
        flush = 1'b0; ifid_write = 1'b1; #1;
        n_cmp++; if (ifid_valid !== 1'b0) begin n_bad++; $display("FAIL race_valid: got %b want 0", ifid_valid); end
        n_cmp++; if (ifid_instr !== NOP) begin n_bad++; $display("FAIL race_instr: got %h want %h", ifid_instr, NOP); end
        n_cmp++; if (imem_addr !== 32'h300) begin n_bad++; $display("FAIL race_addr: got %h want 300", imem_addr); end
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (ifid_valid === 1'b1) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL race_timeout: got no valid want valid"); end
        n_cmp++; if (ifid_pc !== 32'h300) begin n_bad++; $display("FAIL race_target_pc: got %h want 300", ifid_pc); end
        n_cmp++; if (ifid_instr !== 32'hB00) begin n_bad++; $display("FAIL race_target_instr: got %h want b00", ifid_instr); end
    endtask

    task automatic test_wrap();
        bit ok = 1'b0;
        do_reset(1);
        repeat (2) @(negedge clk);
        #1;
        flush = 1'b1; branch_target = 32'hFFFF_FFFE;
        @(negedge clk); #1;
        flush = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (ifid_valid === 1'b1) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok || ifid_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_top_pc: got %h want fffffffc", ifid_pc); end
        @(negedge clk); #1;
        n_cmp++; if (ifid_pc !== 32'h0) begin n_bad++; $display("FAIL wrap_zero_pc: got %h want 0", ifid_pc); end
        n_cmp++; if (ifid_instr !== 32'hA00) begin n_bad++; $display("FAIL wrap_zero_instr: got %h want a00", ifid_instr); end
    endtask

    task automatic test_perf();
        bit ok = 1'b0;
        do_reset(1);
        #1;
        n_cmp++; if (stall_cycles !== 32'h0 || flush_count !== 32'h0) begin n_bad++; $display("FAIL perf_reset: got %0d/%0d want 0/0", stall_cycles, flush_count); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (ifid_valid === 1'b1) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL perf_timeout: got no valid want valid"); end
        ifid_write = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        ifid_write = 1'b1; flush = 1'b1; branch_target = 32'h40;
        @(negedge clk); #1;
        flush = 1'b0;
        @(negedge clk); #1;
        flush = 1'b1;
        @(negedge clk); #1;
        flush = 1'b0;
        @(negedge clk); #1;
`ifdef FETCH_PERF_CNT_EN
        n_cmp++; if (stall_cycles !== 32'd4) begin n_bad++; $display("FAIL perf_stall: got %0d want 4", stall_cycles); end
        n_cmp++; if (flush_count !== 32'd2) begin n_bad++; $display("FAIL perf_flush: got %0d want 2", flush_count); end
`else
        n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL perf_off_stall: got %0d want 0", stall_cycles); end
        n_cmp++; if (flush_count !== 32'd0) begin n_bad++; $display("FAIL perf_off_flush: got %0d want 0", flush_count); end
`endif
        n_cmp++; if (imem_addr === 32'h0) begin n_bad++; $display("FAIL perf_pc_moved: got %h want nonzero", imem_addr); end
        rst = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (stall_cycles !== 32'h0 || flush_count !== 32'h0) begin n_bad++; $display("FAIL midrun_rst_cnt: got %0d/%0d want 0/0", stall_cycles, flush_count); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL midrun_rst_pc: got %h want 0", imem_addr); end
        n_cmp++; if (imem_req !== 1'b0 || ifid_valid !== 1'b0) begin n_bad++; $display("FAIL midrun_rst_ctl: got %b/%b want 0/0", imem_req, ifid_valid); end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_straight();
        test_stall();
        test_flush();
        test_flush_race();
        test_wrap();
        test_perf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
